// File: rtl/fetch_cycle.sv
// fetch_cycle: IF stage of the RV32I pipeline.
// Owns the PC, issues one instruction-memory request at a time, and loads the
// IF/ID register. A one-entry hold buffer keeps a response that arrives while
// decode is stalled, and redirects from EX kill in-flight or buffered fetches.
module fetch_cycle #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        IF_stall_en,
    input  logic        IF_rst_n,
    input  logic        EX_pc_sel,
    input  logic [31:0] EX_pc_target,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_valid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] ID_inst,
    output logic [31:0] ID_pc,
    output logic [31:0] ID_pc_four,
    output logic        ID_valid
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,  // ready to issue a request at pc
        S_WAIT = 2'd1,  // request outstanding, response wanted
        S_DROP = 2'd2,  // request outstanding, response is stale
        S_HOLD = 2'd3   // response parked in hold buffer
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc_four_q, id_pc_four_d;
    logic        id_valid_q, id_valid_d;

    logic        accept;
    logic        redir;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic        req;
    logic [31:0] addr;
    logic        deliver;
    logic [31:0] deliver_inst;

    // Fetch FSM: next state, next PC, hold buffer and memory request.
    always_comb begin
        accept       = IF_stall_en & IF_rst_n;
        redir        = EX_pc_sel;
        target       = EX_pc_target & ~32'd3;
        pc_plus4     = pc_q + 32'd4;
        state_d      = state_q;
        pc_d         = pc_q;
        hold_d       = hold_q;
        req          = 1'b0;
        addr         = pc_q;
        deliver      = 1'b0;
        deliver_inst = imem_rdata_i;
        case (state_q)
            S_REQ: begin
                if (redir) begin
                    pc_d = target;
                end else begin
                    req     = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_valid_i) begin
                    if (redir) begin
                        pc_d    = target;
                        state_d = S_REQ;
                    end else if (accept) begin
                        // Deliver and immediately fetch the next word.
                        deliver = 1'b1;
                        pc_d    = pc_plus4;
                        req     = 1'b1;
                        addr    = pc_plus4;
                    end else begin
                        hold_d  = imem_rdata_i;
                        state_d = S_HOLD;
                    end
                end else if (redir) begin
                    pc_d    = target;
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                // A later redirect while still draining simply retargets.
                if (redir) begin
                    pc_d = target;
                end
                if (imem_valid_i) begin
                    state_d = S_REQ;
                end
            end
            S_HOLD: begin
                if (redir) begin
                    pc_d    = target;
                    state_d = S_REQ;
                end else if (accept) begin
                    deliver      = 1'b1;
                    deliver_inst = hold_q;
                    pc_d         = pc_plus4;
                    state_d      = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // IF/ID register next value: flush > stall > load > bubble.
    always_comb begin
        id_inst_d    = id_inst_q;
        id_pc_d      = id_pc_q;
        id_pc_four_d = id_pc_four_q;
        id_valid_d   = id_valid_q;
        if (!IF_rst_n) begin
            id_inst_d    = NOP_INST;
            id_pc_d      = 32'd0;
            id_pc_four_d = 32'd0;
            id_valid_d   = 1'b0;
        end else if (!IF_stall_en) begin
            id_inst_d    = id_inst_q;
        end else if (deliver) begin
            id_inst_d    = deliver_inst;
            id_pc_d      = pc_q;
            id_pc_four_d = pc_plus4;
            id_valid_d   = 1'b1;
        end else begin
            id_inst_d    = NOP_INST;
            id_pc_d      = 32'd0;
            id_pc_four_d = 32'd0;
            id_valid_d   = 1'b0;
        end
    end

    // State, PC, hold buffer and IF/ID registers.
    always_ff @(posedge clk_i) begin
        hold_q <= hold_d;
        if (rst_i) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            id_inst_q    <= NOP_INST;
            id_pc_q      <= 32'd0;
            id_pc_four_q <= 32'd0;
            id_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            id_inst_q    <= id_inst_d;
            id_pc_q      <= id_pc_d;
            id_pc_four_q <= id_pc_four_d;
            id_valid_q   <= id_valid_d;
        end
    end

    // Memory shares rst_i, so no request is presented while it is asserted.
    assign imem_req_o  = req & ~rst_i;
    assign imem_addr_o = addr;
    assign ID_inst     = id_inst_q;
    assign ID_pc       = id_pc_q;
    assign ID_pc_four  = id_pc_four_q;
    assign ID_valid    = id_valid_q;

endmodule

// File: tb/tb_fetch_cycle.sv
// Testbench for fetch_cycle: variable-latency memory model plus a
// transaction-level reference model of the fetch stage.
module tb_fetch_cycle;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        IF_stall_en;
    logic        IF_rst_n;
    logic        EX_pc_sel;
    logic [31:0] EX_pc_target;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_valid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] ID_inst;
    logic [31:0] ID_pc;
    logic [31:0] ID_pc_four;
    logic        ID_valid;

    always #5 clk = ~clk;

    fetch_cycle #(.RESET_PC(RPC), .NOP_INST(NOP)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .IF_stall_en (IF_stall_en),
        .IF_rst_n    (IF_rst_n),
        .EX_pc_sel   (EX_pc_sel),
        .EX_pc_target(EX_pc_target),
        .imem_req_o  (imem_req_o),
        .imem_addr_o (imem_addr_o),
        .imem_valid_i(imem_valid_i),
        .imem_rdata_i(imem_rdata_i),
        .ID_inst     (ID_inst),
        .ID_pc       (ID_pc),
        .ID_pc_four  (ID_pc_four),
        .ID_valid    (ID_valid)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Memory environment: one pending response, latency in cycles.
    bit          mem_pend = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_data = 32'd0;
    int          lat      = 1;
    bit          lat_rand = 1'b0;
    logic [31:0] key      = 32'd0;

    // Reference model: pc, outstanding/stale request, buffered word, IF/ID.
    logic [31:0] m_pc = RPC;
    bit          m_out = 1'b0;
    bit          m_stale = 1'b0;
    bit          m_full = 1'b0;
    logic [31:0] m_buf = 32'd0;
    logic [31:0] m_inst = NOP;
    logic [31:0] m_idpc = 32'd0;
    logic [31:0] m_idpc4 = 32'd0;
    bit          m_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit st, input bit fn, input bit sel,
                        input logic [31:0] tgt);
        logic        v;
        logic [31:0] d;
        logic [31:0] t;
        bit          acc;
        bit          e_req;
        logic [31:0] e_addr;
        bit          dlv;
        logic [31:0] dinst;
        logic [31:0] dpc;
        logic        s_req;
        logic [31:0] s_addr;
        @(negedge clk);
        v            = mem_pend && (mem_cnt == 0);
        d            = v ? mem_data : $urandom;
        rst_i        = r;
        IF_stall_en  = st;
        IF_rst_n     = fn;
        EX_pc_sel    = sel;
        EX_pc_target = tgt;
        imem_valid_i = v;
        imem_rdata_i = d;
        acc    = st & fn;
        t      = tgt & ~32'd3;
        e_req  = 1'b0;
        e_addr = m_pc;
        dlv    = 1'b0;
        dinst  = 32'd0;
        dpc    = 32'd0;
        if (r) begin
            m_pc = RPC; m_out = 0; m_stale = 0; m_full = 0;
            m_inst = NOP; m_valid = 0; m_idpc = 0; m_idpc4 = 0;
        end else begin
            if (m_full) begin
                if (sel) begin
                    m_full = 0; m_pc = t;
                end else if (acc) begin
                    dlv = 1; dinst = m_buf; dpc = m_pc; m_pc = m_pc + 4; m_full = 0;
                end
            end else if (m_stale) begin
                if (sel) m_pc = t;
                if (v) begin
                    m_stale = 0; m_out = 0;
                end
            end else if (m_out) begin
                if (v) begin
                    m_out = 0;
                    if (sel) m_pc = t;
                    else if (acc) begin
                        dlv = 1; dinst = d; dpc = m_pc; m_pc = m_pc + 4;
                        e_req = 1; e_addr = m_pc; m_out = 1;
                    end else begin
                        m_buf = d; m_full = 1;
                    end
                end else if (sel) begin
                    m_pc = t; m_stale = 1;
                end
            end else begin
                if (sel) m_pc = t;
                else begin
                    e_req = 1; e_addr = m_pc; m_out = 1;
                end
            end
            if (!fn) begin
                m_inst = NOP; m_valid = 0;
            end else if (!st) begin
                m_valid = m_valid;
            end else if (dlv) begin
                m_inst = dinst; m_idpc = dpc; m_idpc4 = dpc + 4; m_valid = 1;
            end else begin
                m_inst = NOP; m_valid = 0;
            end
        end
        #1;
        s_req  = imem_req_o;
        s_addr = imem_addr_o;
        chk("imem_req", {31'd0, s_req}, {31'd0, e_req});
        if (e_req) chk("imem_addr", s_addr, e_addr);
        @(posedge clk);
        #1;
        if (r) begin
            mem_pend = 0;
        end else begin
            if (v) mem_pend = 0;
            else if (mem_pend && mem_cnt > 0) mem_cnt--;
            if (s_req) begin
                mem_pend = 1;
                mem_cnt  = (lat_rand ? int'($urandom_range(1, 4)) : lat) - 1;
                mem_data = s_addr ^ key;
            end
        end
        chk("id_valid", {31'd0, ID_valid}, {31'd0, m_valid});
        chk("id_inst", ID_inst, m_inst);
        if (m_valid) begin
            chk("id_pc", ID_pc, m_idpc);
            chk("id_pc_four", ID_pc_four, m_idpc4);
        end
    endtask

    initial begin
        rst_i = 1; IF_stall_en = 1; IF_rst_n = 1; EX_pc_sel = 0;
        EX_pc_target = 0; imem_valid_i = 0; imem_rdata_i = 0;

        // Reset state
        step(1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        chk("rst_id_pc", ID_pc, 32'd0);
        chk("rst_id_pc_four", ID_pc_four, 32'd0);
        chk("rst_id_inst", ID_inst, NOP);

        // 1-cycle memory returning the address: one instruction per cycle
        lat = 1; key = 32'd0;
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        chk("first_pc", ID_pc, 32'd0);
        chk("first_valid", {31'd0, ID_valid}, 32'd1);
        step(0, 1, 1, 0, 0);
        chk("second_pc", ID_pc, 32'd4);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0);

        // 3-cycle latency
        lat = 3; key = 32'h5A5A_0000;
        for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 0);

        // Stall while a response arrives
        lat = 2;
        for (int i = 0; i < 2; i++) step(0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0);

        // Redirect while waiting
        lat = 3;
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 1, 32'h0000_0100);
        for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 0);

        // Redirect coincident with valid, redirect in hold, flush
        lat = 1;
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
        step(0, 1, 1, 1, 32'h0000_0202);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 32'h0000_0300);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("flush_inst", ID_inst, 32'h0000_0013);
        chk("flush_valid", {31'd0, ID_valid}, 32'd0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);

        // PC wrap, then reset during a wait
        step(0, 1, 1, 1, 32'hFFFF_FFFC);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0);
        lat = 3;
        for (int i = 0; i < 2; i++) step(0, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        chk("midrst_valid", {31'd0, ID_valid}, 32'd0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);

        // Random traffic
        lat_rand = 1; key = $urandom;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < 85,
                 $urandom_range(0, 99) < 92,
                 $urandom_range(0, 99) < 10,
                 $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
